// File: rtl/acq_pkg.sv
// acq_pkg
//   Shared constants and helpers for the acquire-engine correlation datapath.
//   COUNT_W        : width of one popcount lane (ones out of 7 XNOR bits).
//   BITS_PER_COUNT : correlation bits summarised by one lane count.
//   clog2          : elaboration-time ceiling log2 used to size lane sums.
package acq_pkg;

   localparam int COUNT_W        = 3;
   localparam int BITS_PER_COUNT = 7;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lane_sum_tree.sv
// lane_sum_tree
//   Combinational sum of LANES packed 3-bit popcounts.
//   Ports:
//     counts : input  [COUNT_W*LANES-1:0]  lane k = counts[3k+2:3k]
//     sum    : output [SUM_W-1:0]          total of all lanes (max 7*LANES)
module lane_sum_tree
   import acq_pkg::*;
#(
   parameter  int LANES = 8,
   localparam int SUM_W = COUNT_W + clog2(LANES)
) (
   input  logic [COUNT_W*LANES-1:0] counts,
   output logic [SUM_W-1:0]         sum
);

   // SUM_W holds 7*LANES exactly, so the running sum never wraps.
   always_comb begin
      sum = '0;
      for (int k = 0; k < LANES; k++) begin
         sum = sum + SUM_W'(counts[k*COUNT_W +: COUNT_W]);
      end
   end

endmodule

// File: rtl/popcount_accumulator.sv
// popcount_accumulator
//   Sums LANES popcounts per beat, integrates over a window closed by in_last
//   and reports ones total plus bipolar correlation (2*ones - bits) over a
//   valid/ready handshake.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     in_valid              : input beat qualifier (never stalled)
//     in_count[3*LANES-1:0] : packed lane counts
//     in_last               : beat closes the window (qualified by in_valid)
//     out_valid, out_ready  : result handshake
//     out_corr[ACC_W:0]     : signed correlation of the window
//     out_ones[ACC_W-1:0]   : ones total of the window
//     out_sat               : an accumulator saturated during the window
//     overrun, overrun_clr  : sticky "result overwritten unaccepted" flag / clear
module popcount_accumulator
   import acq_pkg::*;
#(
   parameter  int LANES = 8,
   parameter  int ACC_W = 16,
   localparam int SUM_W = COUNT_W + clog2(LANES)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [COUNT_W*LANES-1:0]  in_count,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [ACC_W:0]     out_corr,
   output logic [ACC_W-1:0]          out_ones,
   output logic                      out_sat,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam logic [ACC_W-1:0] BITS_BEAT = ACC_W'(BITS_PER_COUNT * LANES);

   // Saturating add; MSB of the result flags that the ceiling was hit.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
      logic [ACC_W:0] wide;
      wide = {1'b0, a} + {1'b0, b};
      if (wide[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
      return wide;
   endfunction

   // 2*ones - bits evaluated at ACC_W+2 bits, truncated to the output width.
   function automatic logic signed [ACC_W:0] to_corr(input logic [ACC_W-1:0] ones,
                                                     input logic [ACC_W-1:0] bits);
      logic signed [ACC_W+1:0] wide;
      wide = $signed({1'b0, ones, 1'b0}) - $signed({2'b00, bits});
      return wide[ACC_W:0];
   endfunction

   logic [SUM_W-1:0] lane_sum_p0;
   logic [SUM_W-1:0] lane_sum_p1;
   logic             vld_p1;
   logic             last_p1;

   logic [ACC_W-1:0] ones_p2;
   logic [ACC_W-1:0] bits_p2;
   logic             win_sat_p2;

   logic [ACC_W:0]   ones_add;
   logic [ACC_W:0]   bits_add;
   logic [ACC_W-1:0] ones_nxt;
   logic [ACC_W-1:0] bits_nxt;
   logic             beat_sat;
   logic             load;

   lane_sum_tree #(.LANES(LANES)) u_tree (
      .counts (in_count),
      .sum    (lane_sum_p0)
   );

   // ---- S1: lane sum register ----
   always_ff @(posedge clk) begin
      lane_sum_p1 <= lane_sum_p0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= in_valid;
         last_p1 <= in_valid & in_last;
      end
   end

   // ---- S2: window accumulation ----
   always_comb begin
      ones_add = sat_add(ones_p2, ACC_W'(lane_sum_p1));
      bits_add = sat_add(bits_p2, BITS_BEAT);
      ones_nxt = ones_add[ACC_W-1:0];
      bits_nxt = bits_add[ACC_W-1:0];
      beat_sat = ones_add[ACC_W] | bits_add[ACC_W];
      load     = vld_p1 & last_p1;
   end

   // Closing beat clears the window in the same cycle so the next beat
   // starts fresh with no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         ones_p2    <= '0;
         bits_p2    <= '0;
         win_sat_p2 <= 1'b0;
      end else if (vld_p1) begin
         if (last_p1) begin
            ones_p2    <= '0;
            bits_p2    <= '0;
            win_sat_p2 <= 1'b0;
         end else begin
            ones_p2    <= ones_nxt;
            bits_p2    <= bits_nxt;
            win_sat_p2 <= win_sat_p2 | beat_sat;
         end
      end
   end

   // ---- Result register and handshake ----
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ones  <= '0;
         out_corr  <= '0;
         out_sat   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_ones  <= ones_nxt;
            out_corr  <= to_corr(ones_nxt, bits_nxt);
            out_sat   <= win_sat_p2 | beat_sat;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // Set has priority over a simultaneous clear.
         if (load && out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_popcount_accumulator.sv
module tb_popcount_accumulator;

   localparam int LANES = 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    in_valid;
   logic [3*LANES-1:0]      in_count;
   logic                    in_last;
   logic                    out_ready;
   logic                    overrun_clr;

   logic                    out_valid;
   logic signed [16:0]      out_corr;
   logic [15:0]             out_ones;
   logic                    out_sat;
   logic                    overrun;

   logic                    out_valid8;
   logic signed [8:0]       out_corr8;
   logic [7:0]              out_ones8;
   logic                    out_sat8;
   logic                    overrun8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   popcount_accumulator #(.LANES(LANES), .ACC_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_corr(out_corr), .out_ones(out_ones), .out_sat(out_sat),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   popcount_accumulator #(.LANES(LANES), .ACC_W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count),
      .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
      .out_corr(out_corr8), .out_ones(out_ones8), .out_sat(out_sat8),
      .overrun(overrun8), .overrun_clr(overrun_clr)
   );

   task automatic beat(input logic [2:0] c, input logic last);
      in_valid = 1'b1;
      in_count = {LANES{c}};
      in_last  = last;
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic last);
      in_valid = 1'b0;
      in_count = '0;
      in_last  = last;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_count = '0; in_last = 1'b0;
      out_ready = 1'b1; overrun_clr = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (out_ones !== 16'd0) begin errors++; $display("FAIL reset_ones got=%0d exp=0", out_ones); end
      checks++; if (out_corr !== 17'sd0) begin errors++; $display("FAIL reset_corr got=%0d exp=0", out_corr); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0b exp=0", out_sat); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
   endtask

   task automatic test_full_ones();
      out_ready = 1'b1;
      beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_latency got=%0b exp=0", out_valid); end
      idle(1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%0b exp=1", out_valid); end
      checks++; if (out_ones !== 16'd224) begin errors++; $display("FAIL full_ones got=%0d exp=224", out_ones); end
      checks++; if (out_corr !== 17'sd224) begin errors++; $display("FAIL full_corr got=%0d exp=224", out_corr); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL full_sat got=%0b exp=0", out_sat); end
      idle(1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drop got=%0b exp=0", out_valid); end
   endtask

   task automatic test_zero_and_half();
      out_ready = 1'b1;
      // An in_last without in_valid mid-window must not close it.
      beat(3'd0, 1'b0); beat(3'd0, 1'b0); idle(1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_last got=%0b exp=0", out_valid); end
      beat(3'd0, 1'b0); beat(3'd0, 1'b1); idle(1'b0);
      checks++; if (out_ones !== 16'd0) begin errors++; $display("FAIL zero_ones got=%0d exp=0", out_ones); end
      checks++; if (out_corr !== -17'sd224) begin errors++; $display("FAIL zero_corr got=%0d exp=-224", out_corr); end
      beat(3'd4, 1'b0); beat(3'd4, 1'b1); idle(1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL half_valid got=%0b exp=1", out_valid); end
      checks++; if (out_ones !== 16'd64) begin errors++; $display("FAIL half_ones got=%0d exp=64", out_ones); end
      checks++; if (out_corr !== 17'sd16) begin errors++; $display("FAIL half_corr got=%0d exp=16", out_corr); end
      idle(1'b0);
   endtask

   task automatic test_back_to_back();
      logic [15:0]        exp_ones;
      logic signed [16:0] exp_corr;
      out_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 7) beat(3'(c), 1'b1);
         else idle(1'b0);
         if (c >= 2) begin
            exp_ones = 16'(8 * (c - 1));
            exp_corr = 17'(16 * (c - 1) - 56);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d got=%0b exp=1", c - 1, out_valid); end
            checks++; if (out_ones !== exp_ones) begin errors++; $display("FAIL b2b_ones c=%0d got=%0d exp=%0d", c - 1, out_ones, exp_ones); end
            checks++; if (out_corr !== exp_corr) begin errors++; $display("FAIL b2b_corr c=%0d got=%0d exp=%0d", c - 1, out_corr, exp_corr); end
         end
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
      idle(1'b0);
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      beat(3'd2, 1'b1); beat(3'd3, 1'b1);
      checks++; if (out_ones !== 16'd16) begin errors++; $display("FAIL ovr_first got=%0d exp=16", out_ones); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
      idle(1'b0);
      checks++; if (out_ones !== 16'd24) begin errors++; $display("FAIL ovr_second got=%0d exp=24", out_ones); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
      idle(1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got=%0b exp=1", out_valid); end
      checks++; if (out_corr !== -17'sd8) begin errors++; $display("FAIL ovr_corr got=%0d exp=-8", out_corr); end
      out_ready = 1'b1;
      idle(1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%0b exp=0", out_valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
      overrun_clr = 1'b1;
      idle(1'b0);
      overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b1);
      idle(1'b0);
      checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL sat_valid got=%0b exp=1", out_valid8); end
      checks++; if (out_ones8 !== 8'd255) begin errors++; $display("FAIL sat_ones got=%0d exp=255", out_ones8); end
      checks++; if (out_corr8 !== 9'sd255) begin errors++; $display("FAIL sat_corr got=%0d exp=255", out_corr8); end
      checks++; if (out_sat8 !== 1'b1) begin errors++; $display("FAIL sat_flag got=%0b exp=1", out_sat8); end
      checks++; if (out_ones !== 16'd280) begin errors++; $display("FAIL wide_ones got=%0d exp=280", out_ones); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL wide_sat got=%0b exp=0", out_sat); end
      beat(3'd1, 1'b1);
      idle(1'b0);
      checks++; if (out_ones8 !== 8'd8) begin errors++; $display("FAIL sat_next_ones got=%0d exp=8", out_ones8); end
      checks++; if (out_corr8 !== -9'sd40) begin errors++; $display("FAIL sat_next_corr got=%0d exp=-40", out_corr8); end
      checks++; if (out_sat8 !== 1'b0) begin errors++; $display("FAIL sat_next_flag got=%0b exp=0", out_sat8); end
      idle(1'b0);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      beat(3'd5, 1'b1);
      beat(3'd7, 1'b0); beat(3'd7, 1'b0); beat(3'd7, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pending got=%0b exp=1", out_valid); end
      reset = 1'b1;
      idle(1'b0);
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
      out_ready = 1'b1;
      beat(3'd7, 1'b1);
      idle(1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid got=%0b exp=1", out_valid); end
      checks++; if (out_ones !== 16'd56) begin errors++; $display("FAIL rst_fresh_ones got=%0d exp=56", out_ones); end
      checks++; if (out_corr !== 17'sd56) begin errors++; $display("FAIL rst_fresh_corr got=%0d exp=56", out_corr); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_fresh_sat got=%0b exp=0", out_sat); end
      idle(1'b0);
   endtask

   initial begin
      test_reset();
      test_full_ones();
      test_zero_and_half();
      test_back_to_back();
      test_overrun();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
